instr_fetch_unit: RTL and testbench

Fetches 32-bit MIPS instruction words from the instruction memory over a req/ack handshake, buffers them with their PCs in a small FIFO, and presents them to the core's decode stage over a valid/ready interface. It is the reading end of the instruction-memory interface. It replaces direct driving of a single instruction register, so the core can consume a sequential, PC-tagged instruction stream and redirect it on branches and jumps.

---
 rtl/mipspkg.sv | 21 ++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mipspkg.sv
// Shared types for the instruction fetch path.
package mipspkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef logic [31:0] word_t;

  localparam int unsigned INSTR_BYTES = 4;

  // One buffered instruction tagged with its fetch address.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries for the fetch unit.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   flush             empties the FIFO; overrides push and pop
//   push, push_pc,
//   push_instr        write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head_pc,
//   head_instr        head entry, read from flop storage
//   count             occupied entries, one bit wider than the pointers
module fetch_fifo
  import mipspkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  input  logic             pop,
  output logic [31:0]      head_pc,
  output logic [31:0]      head_instr,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push_en;
  logic                     pop_en;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_en  = push && (count_q != CNT_W'(DEPTH));
    pop_en   = pop && (count_q != '0);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = '{pc: push_pc, instr: push_instr};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign head_instr = mem_q[rd_ptr_q].instr;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests sequential words from instruction memory
// over req/ack, buffers them PC-tagged in a FIFO and hands them to decode
// over valid/ready. A redirect flushes the stream and restarts at a new PC.
// Ports:
//   clk, reset                  clock; synchronous active-low reset
//   imem_req, imem_addr         fetch request and word address (registered)
//   imem_ack, imem_rdata        memory accept and returned instruction
//   inst_valid, inst_data,
//   inst_pc, inst_ready         decode-side valid/ready stream
//   redirect, redirect_pc       flush and restart fetching
//   fifo_count                  buffered entries
module instr_fetch_unit
  import mipspkg::*;
#(
  parameter int unsigned  DEPTH    = 4,
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst_data,
  output logic [31:0]      inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] fifo_count
);

  fetch_state_e     state_q, state_d;
  word_t            fetch_pc_q, fetch_pc_d;
  word_t            addr_q, addr_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             push;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             redirect_lsb_unused;

  // Word alignment discards the low address bits.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Next-state, FIFO control and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (req_q && imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
        end
        pop = valid_q && inst_ready;
      end
      DISCARD: begin
        // The abandoned request completes here; its data is dropped.
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A still-unanswered request must be drained before the new PC is sent.
    if (redirect) begin
      flush      = 1'b1;
      push       = 1'b0;
      pop        = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      state_d    = (req_q && !imem_ack) ? DISCARD : FETCH;
    end

    count_nxt = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    valid_d   = (count_nxt != '0);
    req_d     = (state_d == DISCARD) ||
                ((state_d == FETCH) && (count_nxt < CNT_W'(DEPTH)));
    // DISCARD keeps presenting the address the memory has not yet answered.
    addr_d    = (state_d == DISCARD) ? addr_q : fetch_pc_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_pc    (fetch_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (inst_pc),
    .head_instr (inst_data),
    .count      (count)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: three program words, elsewhere addr ^ 5A5A_0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h8C05_1234;
      32'h0000_0004: mem_word = 32'h0085_3FE0;
      32'h0000_0008: mem_word = 32'h2064_2345;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    step(); step();
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_addr",  imem_addr,       32'h0);
    check("rst_data",  inst_data,       32'h0);
    check("rst_pc",    inst_pc,         32'h0);

    // First fetch
    reset = 1'b1;
    step();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,     32'h0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_data",  inst_data,       32'h8C05_1234);
    check("first_pc",    inst_pc,         32'h0);
    check("first_count", 32'(fifo_count), 32'd1);

    // Streaming with zero-wait memory
    inst_ready = 1'b1;
    imem_ack   = 1'b1;
    step();
    check("stream_pc1",   inst_pc,   32'h4);
    check("stream_data1", inst_data, 32'h0085_3FE0);
    check("stream_addr1", imem_addr, 32'h8);
    step();
    check("stream_pc2",    inst_pc,         32'h8);
    check("stream_data2",  inst_data,       32'h2064_2345);
    check("stream_addr2",  imem_addr,       32'hC);
    check("stream_count2", 32'(fifo_count), 32'd1);

    // Backpressure until full
    inst_ready = 1'b0;
    step(); step(); step();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req",   32'(imem_req),   32'd0);
    check("full_addr",  imem_addr,       32'h18);
    step();
    check("full_hold_count", 32'(fifo_count), 32'd4);
    check("full_hold_addr",  imem_addr,       32'h18);

    // One pop re-raises the request
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    imem_ack   = 1'b0;
    check("resume_req",   32'(imem_req),   32'd1);
    check("resume_addr",  imem_addr,       32'h18);
    check("resume_count", 32'(fifo_count), 32'd3);
    check("resume_pc",    inst_pc,         32'hC);

    // Wait-state memory: request held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_req",   32'(imem_req),   32'd1);
      check("ws_addr",  imem_addr,       32'h18);
      check("ws_count", 32'(fifo_count), 32'd3);
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("ws_push_count", 32'(fifo_count), 32'd4);
    check("ws_push_req",   32'(imem_req),   32'd0);

    // Drain with no acks
    inst_ready = 1'b1;
    step();
    check("drain_pc16", inst_pc, 32'h10);
    step();
    check("drain_pc20", inst_pc, 32'h14);
    step();
    check("drain_pc24",   inst_pc,   32'h18);
    check("drain_data24", inst_data, 32'h5A5A_0018);
    step();
    check("drain_valid", 32'(inst_valid), 32'd0);
    check("drain_addr",  imem_addr,       32'h1C);
    check("drain_req",   32'(imem_req),   32'd1);

    // Redirect with a request outstanding at 0x1C
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("rd_valid", 32'(inst_valid), 32'd0);
    check("rd_count", 32'(fifo_count), 32'd0);
    check("rd_req",   32'(imem_req),   32'd1);
    check("rd_addr",  imem_addr,       32'h1C);
    step();
    check("rd_hold_addr", imem_addr, 32'h1C);
    imem_ack = 1'b1;
    step();
    check("rd_drop_valid", 32'(inst_valid), 32'd0);
    check("rd_new_addr",   imem_addr,       32'h100);
    check("rd_new_req",    32'(imem_req),   32'd1);
    step();
    check("rd_out_valid", 32'(inst_valid), 32'd1);
    check("rd_out_pc",    inst_pc,         32'h100);
    check("rd_out_data",  inst_data,       32'h5A5A_0100);

    // Redirect together with ack and pop, to the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("sim_valid", 32'(inst_valid), 32'd0);
    check("sim_count", 32'(fifo_count), 32'd0);
    check("sim_addr",  imem_addr,       32'hFFFF_FFFC);
    step();
    check("wrap_pc1",   inst_pc,   32'hFFFF_FFFC);
    check("wrap_data1", inst_data, 32'hA5A5_FFFC);
    check("wrap_addr1", imem_addr, 32'h0);
    step();
    check("wrap_pc2",   inst_pc,   32'h0);
    check("wrap_data2", inst_data, 32'h8C05_1234);
    check("wrap_addr2", imem_addr, 32'h4);

    // Reset with a request outstanding
    imem_ack = 1'b0;
    reset    = 1'b0;
    step();
    check("mr_req",   32'(imem_req),   32'd0);
    check("mr_valid", 32'(inst_valid), 32'd0);
    check("mr_count", 32'(fifo_count), 32'd0);
    check("mr_addr",  imem_addr,       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
